// File: rtl/rr_dec_arbiter.sv
// Round-robin arbiter that time-shares a 4-to-16 enable decoder among 16 requesters.
// Drives the decoder select/enable plus a matching registered one-hot grant, with a hold limit.
module rr_dec_arbiter #(
  parameter int MAX_HOLD = 8,
  parameter int CW       = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] req,
  input  logic        done,
  output logic [3:0]  W,
  output logic        En,
  output logic [0:15] gnt,
  output logic        busy,
  output logic        timeout,
  output logic [1:0]  state_dbg
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] GRANT = 2'd1;

  // Handshake: req[i] is a level request; the owner may end its grant early with a
  // one-cycle done pulse. done is only looked at while a grant is active.

  logic [1:0]    state;
  logic [3:0]    ptr;
  logic [CW-1:0] cnt;

  logic [31:0]   req_dbl;
  logic [15:0]   req_rot;
  logic [3:0]    pick_off;
  logic [3:0]    pick;
  logic          pick_vld;

  logic          owner_req;
  logic          at_max;
  logic          release_now;
  logic          timeout_cause;

  function automatic logic [0:15] one_hot(input logic [3:0] idx);
    logic [0:15] v;
    for (int i = 0; i < 16; i++) begin
      v[i] = (idx == 4'(i));
    end
    return v;
  endfunction

  // Rotate so bit 0 of req_rot is slot ptr; the lowest set bit is the winner.
  always_comb begin
    req_dbl  = {req, req} >> ptr;
    req_rot  = req_dbl[15:0];
    pick_vld = 1'b0;
    pick_off = 4'd0;
    for (int k = 15; k >= 0; k--) begin
      if (req_rot[k]) begin
        pick_vld = 1'b1;
        pick_off = 4'(k);
      end
    end
    pick = ptr + pick_off;
  end

  always_comb begin
    owner_req     = req[W];
    at_max        = (cnt == CW'(MAX_HOLD - 1));
    release_now   = !owner_req || done || at_max;
    timeout_cause = at_max && owner_req && !done;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      W       <= 4'd0;
      En      <= 1'b0;
      gnt     <= '0;
      busy    <= 1'b0;
      timeout <= 1'b0;
      ptr     <= 4'd0;
      cnt     <= '0;
    end else begin
      timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_vld) begin
            W     <= pick;
            En    <= 1'b1;
            gnt   <= one_hot(pick);
            busy  <= 1'b1;
            cnt   <= '0;
            state <= GRANT;
          end
        end
        GRANT: begin
          if (release_now) begin
            // W is kept so the decoder select stays stable through the idle gap.
            En      <= 1'b0;
            gnt     <= '0;
            busy    <= 1'b0;
            ptr     <= W + 4'd1;
            timeout <= timeout_cause;
            state   <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          En    <= 1'b0;
          gnt   <= '0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  assign state_dbg = state;

endmodule
